// File: rtl/fpm_operand_front_end_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fpm_pkg
// Brief    : Shared binary32 field widths, constants and field bundle type.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package fpm_pkg;

  localparam int          EXP_W    = 8;
  localparam int          FRAC_W   = 23;
  localparam int          MAN_W    = 33;
  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;

  // Mantissa is zero-extended so the 32x32 multiplier sees a guard bit.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MAN_W-1:0]  man;
    logic              zero;
    logic              inf;
    logic              nan;
    logic              sub;
  } fp_fields_t;

endpackage : fpm_pkg
`default_nettype wire

// File: rtl/fpm_operand_front_end_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fpm_operand_front_end_if
// Brief    : Operand / decoded-field bundle of the multiplier front end.
//            FPM_FE_VALID_EN adds in_valid/out_valid.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface fpm_operand_front_end_if;
  import fpm_pkg::*;

  logic [31:0]       a;
  logic [31:0]       b;
  logic [31:0]       a_q;
  logic [31:0]       b_q;
  logic [MAN_W-1:0]  man_a;
  logic [MAN_W-1:0]  man_b;
  logic [EXP_W-1:0]  exp_a;
  logic [EXP_W-1:0]  exp_b;
  logic              sign_a;
  logic              sign_b;
  logic              zero_a;
  logic              zero_b;
  logic              inf_a;
  logic              inf_b;
  logic              nan_a;
  logic              nan_b;
  logic              sub_a;
  logic              sub_b;
`ifdef FPM_FE_VALID_EN
  logic              in_valid;
  logic              out_valid;
`endif

  modport master (
    output a, b,
`ifdef FPM_FE_VALID_EN
    output in_valid,
    input  out_valid,
`endif
    input  a_q, b_q, man_a, man_b, exp_a, exp_b, sign_a, sign_b,
    input  zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sub_a, sub_b
  );

  modport slave (
    input  a, b,
`ifdef FPM_FE_VALID_EN
    input  in_valid,
    output out_valid,
`endif
    output a_q, b_q, man_a, man_b, exp_a, exp_b, sign_a, sign_b,
    output zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sub_a, sub_b
  );

endinterface : fpm_operand_front_end_if
`default_nettype wire

// File: rtl/fpm_operand_front_end_field_extract.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fpm_field_extract
// Brief    : Combinational split of a binary32 word into sign, exponent,
//            hidden-bit mantissa and class flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fpm_field_extract
  import fpm_pkg::*;
(
  input  logic [31:0] word,
  output fp_fields_t  fields
);

  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W-1:0] w_frac;
  logic              w_hidden;
  logic              w_exp_zero;
  logic              w_exp_max;
  logic              w_frac_zero;

  assign w_exp       = word[30:23];
  assign w_frac      = word[22:0];
  // Hidden bit is set for every non-zero exponent, Inf/NaN included.
  assign w_hidden    = |w_exp;
  assign w_exp_zero  = (w_exp == '0);
  assign w_exp_max   = (w_exp == EXP_MAX);
  assign w_frac_zero = (w_frac == '0);

  always_comb begin
    fields      = '0;
    fields.sign = word[31];
    fields.exp  = w_exp;
    fields.man  = {{(MAN_W-FRAC_W-1){1'b0}}, w_hidden, w_frac};
    fields.zero = w_exp_zero &  w_frac_zero;
    fields.sub  = w_exp_zero & ~w_frac_zero;
    fields.inf  = w_exp_max  &  w_frac_zero;
    fields.nan  = w_exp_max  & ~w_frac_zero;
  end

endmodule : fpm_field_extract
`default_nettype wire

// File: rtl/fpm_operand_front_end.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fpm_operand_front_end
// Brief    : Two-stage operand register / field decode front end of the
//            binary32 multiplier. FPM_FE_VALID_EN adds a valid pipe.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fpm_operand_front_end
  import fpm_pkg::*;
#(
  parameter int EXP_W  = fpm_pkg::EXP_W,
  parameter int FRAC_W = fpm_pkg::FRAC_W,
  parameter int MAN_W  = fpm_pkg::MAN_W
)(
  input  logic                     clk,
  input  logic                     rst,
  fpm_operand_front_end_if.slave   bus
);

  localparam int WORD_W = 1 + EXP_W + FRAC_W;

  logic [WORD_W-1:0] r_a1;
  logic [WORD_W-1:0] r_b1;
  logic [WORD_W-1:0] r_a2;
  logic [WORD_W-1:0] r_b2;
  fp_fields_t        w_fa;
  fp_fields_t        w_fb;
  fp_fields_t        r_fa;
  fp_fields_t        r_fb;
  logic              w_ld1;
  logic              w_ld2;

`ifdef FPM_FE_VALID_EN
  logic r_v1;
  logic r_v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= bus.in_valid;
      r_v2 <= r_v1;
    end
  end

  // Each stage only advances when the data it would capture is valid.
  assign w_ld1         = bus.in_valid;
  assign w_ld2         = r_v1;
  assign bus.out_valid = r_v2;
`else
  assign w_ld1 = 1'b1;
  assign w_ld2 = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a1 <= '0;
      r_b1 <= '0;
    end else if (w_ld1) begin
      r_a1 <= bus.a;
      r_b1 <= bus.b;
    end
  end

  fpm_field_extract u_extract_a (
    .word   (r_a1),
    .fields (w_fa)
  );

  fpm_field_extract u_extract_b (
    .word   (r_b1),
    .fields (w_fb)
  );

  // Flags reset to 0; the flushed zeros decode on the first edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a2 <= '0;
      r_b2 <= '0;
      r_fa <= '0;
      r_fb <= '0;
    end else if (w_ld2) begin
      r_a2 <= r_a1;
      r_b2 <= r_b1;
      r_fa <= w_fa;
      r_fb <= w_fb;
    end
  end

  assign bus.a_q    = r_a2;
  assign bus.b_q    = r_b2;
  assign bus.sign_a = r_fa.sign;
  assign bus.sign_b = r_fb.sign;
  assign bus.exp_a  = r_fa.exp;
  assign bus.exp_b  = r_fb.exp;
  assign bus.man_a  = r_fa.man;
  assign bus.man_b  = r_fb.man;
  assign bus.zero_a = r_fa.zero;
  assign bus.zero_b = r_fb.zero;
  assign bus.inf_a  = r_fa.inf;
  assign bus.inf_b  = r_fb.inf;
  assign bus.nan_a  = r_fa.nan;
  assign bus.nan_b  = r_fb.nan;
  assign bus.sub_a  = r_fa.sub;
  assign bus.sub_b  = r_fb.sub;

endmodule : fpm_operand_front_end
`default_nettype wire

// File: tb/tb_fpm_operand_front_end.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_fpm_operand_front_end
// Brief    : Scoreboard bench for the multiplier operand front end.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fpm_operand_front_end;
  import fpm_pkg::*;

  localparam int K_DATA   = 0;  // operand pair, expect decoded fields
  localparam int K_ZERO   = 1;  // everything held at 0 by reset
  localparam int K_DECODE = 2;  // flushed zero operands decoded after reset
  localparam int K_HOLD   = 3;  // earlier data held, out_valid low

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
    int          due;
  } item_t;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     cyc = 0;
  int     vectors = 0;
  int     miscompares = 0;
  item_t  q[$];

  fpm_operand_front_end_if bus ();

  fpm_operand_front_end dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference decode straight from the binary32 layout, using arithmetic.
  function automatic logic [45:0] model(input logic [31:0] w);
    int unsigned e, f, s;
    logic [32:0] man;
    logic [7:0]  e8;
    s   = w / 32'h8000_0000;
    e   = (w / (1 << 23)) % 256;
    f   = w % (1 << 23);
    man = (e != 0) ? 33'(f + (1 << 23)) : 33'(f);
    e8  = 8'(e);
    return {s[0], e8, man, (e == 0 && f == 0), (e == 255 && f == 0),
            (e == 255 && f != 0), (e == 0 && f != 0)};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] f;
    int          sel;
    sel = int'($urandom_range(0, 3));
    e   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
    f   = ($urandom_range(0, 2) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, f};
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    bus.a = a;
    bus.b = b;
`ifdef FPM_FE_VALID_EN
    bus.in_valid = 1'b1;
`endif
    q.push_back('{kind: K_DATA, a: a, b: b, due: cyc + 2});
  endtask

  always @(negedge clk) begin
    item_t       it;
    logic [155:0] got, expv;
    logic        gv, ev;
    while (q.size() > 0 && q[0].due <= cyc) begin
      it = q.pop_front();
      vectors++;
      if (it.due < cyc) begin
        miscompares++;
        $display("FAIL overdue: item due at cycle %0d not checked by cycle %0d", it.due, cyc);
      end else begin
        got = {bus.a_q, bus.b_q,
               bus.sign_a, bus.exp_a, bus.man_a, bus.zero_a, bus.inf_a, bus.nan_a, bus.sub_a,
               bus.sign_b, bus.exp_b, bus.man_b, bus.zero_b, bus.inf_b, bus.nan_b, bus.sub_b};
        gv = 1'b0;
        ev = 1'b0;
        case (it.kind)
          K_DATA, K_HOLD: expv = {it.a, it.b, model(it.a), model(it.b)};
`ifdef FPM_FE_VALID_EN
          K_DECODE:       expv = '0;
`else
          K_DECODE:       expv = {32'h0, 32'h0, model(32'h0), model(32'h0)};
`endif
          default:        expv = '0;
        endcase
`ifdef FPM_FE_VALID_EN
        gv = bus.out_valid;
        ev = (it.kind == K_DATA);
`endif
        if ({got, gv} !== {expv, ev}) begin
          miscompares++;
          $display("FAIL kind%0d a=%h b=%h cyc=%0d: got %h v%b, expected %h v%b",
                   it.kind, it.a, it.b, cyc, got, gv, expv, ev);
        end
      end
    end
  end

  initial begin
    logic [31:0] tmp;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'hFFFF_FFFF;
`ifdef FPM_FE_VALID_EN
    bus.in_valid = 1'b1;
`endif
    q.push_back('{kind: K_ZERO, a: 32'h0, b: 32'h0, due: 1});
    q.push_back('{kind: K_ZERO, a: 32'h0, b: 32'h0, due: 2});
    repeat (2) @(posedge clk);

    // Directed vectors issued back to back, first one right as reset drops.
    @(negedge clk);
    rst = 1'b0;
    q.push_back('{kind: K_DECODE, a: 32'h0, b: 32'h0, due: cyc + 1});
    drive(32'h4000_0000, 32'h4080_0000);
    @(negedge clk); drive(32'h42FA_4000, 32'h4141_0000);
    @(negedge clk); drive(32'h7F80_0000, 32'h7FFF_FFFF);
    @(negedge clk); drive(32'h0000_0000, 32'h8000_0000);
    @(negedge clk); drive(32'h0000_0001, 32'hFF80_0000);
    @(negedge clk); drive(32'h807F_FFFF, 32'h0080_0000);

    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      drive(rand_fp(), rand_fp());
    end
    repeat (4) @(negedge clk);

    // Reset mid-stream: the pair in flight must never reach the outputs.
    @(negedge clk);
    bus.a = rand_fp();
    bus.b = rand_fp();
    @(negedge clk);
    rst   = 1'b1;
    bus.a = rand_fp();
    bus.b = rand_fp();
    q.push_back('{kind: K_ZERO, a: 32'h0, b: 32'h0, due: cyc + 1});
    @(negedge clk);
    rst = 1'b0;
    q.push_back('{kind: K_DECODE, a: 32'h0, b: 32'h0, due: cyc + 1});
    drive(rand_fp(), rand_fp());
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(rand_fp(), rand_fp());
    end

`ifdef FPM_FE_VALID_EN
    @(negedge clk);
    drive(32'h4000_0000, 32'h4080_0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tmp   = rand_fp();
    bus.a = tmp;
    bus.b = ~tmp;
    q.push_back('{kind: K_HOLD, a: 32'h4000_0000, b: 32'h4080_0000, due: cyc + 2});
    q.push_back('{kind: K_HOLD, a: 32'h4000_0000, b: 32'h4080_0000, due: cyc + 3});
`else
    tmp = 32'h0;
`endif

    repeat (6) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d items left, expected 0 (tmp=%h)", q.size(), tmp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fpm_operand_front_end
`default_nettype wire

// File: doc/fpm_operand_front_end.md
Name: fpm_operand_front_end

Overview:
- Front end of the pipelined single-precision (IEEE-754 binary32) floating-point multiplier.
- Registers two raw operands (stage 1), splits each into sign, biased exponent and hidden-bit mantissa (combinational), and registers all fields plus the raw operands (stage 2).
- Feeds the mantissa multiplier and the special-case/exponent logic downstream.
- Fixed 2-cycle latency, one operand pair accepted per cycle, no stall.

Parameters:
- EXP_W, 8, exponent field width; only the default is supported.
- FRAC_W, 23, fraction field width; only the default is supported.
- MAN_W, 33, mantissa output width; zero-extended to feed the 32x32 multiplier with a guard bit.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a  in  32  operand A, raw binary32.
- b  in  32  operand B, raw binary32.
- a_q  out  32  operand A delayed 2 cycles, for downstream special-case muxes.
- b_q  out  32  operand B delayed 2 cycles.
- man_a  out  33  {9'b0, hidden_a, a[22:0]}, registered.
- man_b  out  33  {9'b0, hidden_b, b[22:0]}, registered.
- exp_a  out  8  a[30:23], registered.
- exp_b  out  8  b[30:23], registered.
- sign_a  out  1  a[31], registered.
- sign_b  out  1  b[31], registered.
- zero_a, zero_b  out  1  operand is ±0 (exp==0, frac==0), registered.
- inf_a, inf_b  out  1  exp==8'hFF, frac==0, registered.
- nan_a, nan_b  out  1  exp==8'hFF, frac!=0, registered.
- sub_a, sub_b  out  1  subnormal: exp==0, frac!=0, registered.

Behaviour:
- Stage 1: a1<=a, b1<=b on each rising clk.
- Extraction (combinational from a1/b1): sign = bit31; exp = bits30:23; hidden = |exp (0 for zero/subnormal, 1 otherwise, including Inf/NaN).
- Extraction: man = {9'b0, hidden, frac}, so man[32:24] is always 0. Classification flags follow the port definitions.
- Stage 2: every output register samples the extraction results and a1/b1 on each rising clk.
- Output at edge N+2 reflects inputs sampled at edge N. Throughput is 1 per cycle.
- Reset: when rst=1 at a rising edge, the stage-1 and stage-2 registers all load 0. Outputs are therefore all 0 the cycle after reset.
- Reset decode: zero flags read 1 for the flushed zero operands only after the next un-reset edge computes them. Flags themselves reset to 0.
- Reset mid-stream: in-flight data is discarded. The first valid output appears 2 edges after rst deasserts with new input.
- Fields are passed unmodified: no rounding, no normalisation, no exponent arithmetic. The bias subtraction and sign XOR happen downstream.
- The NaN payload is preserved in man and a_q/b_q.

Optional Feature:
- Macro FPM_FE_VALID_EN.
- Defined: adds ports in_valid (in, 1) and out_valid (out, 1). The valid bit travels the same 2-stage pipe and resets to 0.
- Defined: data registers load only when their stage's valid is 1, otherwise they hold. out_valid asserts exactly 2 edges after an accepted in_valid.
- Undefined: no valid ports; all registers load every cycle as above.

Decomposition:
- Package fpm_pkg holds constants EXP_W, FRAC_W, MAN_W, EXP_BIAS=127, EXP_MAX=8'hFF.
- Package fpm_pkg also holds a packed struct fp_fields_t {sign, exp, man, zero, inf, nan, sub}.
- One natural sub-module: fpm_field_extract. It is combinational, maps 32-bit word to fp_fields_t, and is instantiated twice (A, B) between the two register stages.

Test Plan:
- Reset: rst=1 for 2 edges with a=b=32'hFFFFFFFF -> all outputs 0. After deassert, outputs track inputs with 2-cycle lag.
- a=32'h40000000 (2.0), b=32'h40800000 (4.0) -> 2 edges later: exp_a=8'h80, exp_b=8'h81, man_a=man_b=33'h000800000, signs 0, all flags 0.
- Back-to-back: a=32'h42FA4000, b=32'h41410000 on the next cycle -> exp_a=8'h85, man_a=33'h000FA4000, exp_b=8'h82, man_b=33'h000C10000. Produced one cycle after the previous result, with no bubble.
- Specials: a=32'h7F800000, b=32'h7FFFFFFF -> inf_a=1, exp_a=8'hFF, man_a=33'h000800000; nan_b=1, man_b=33'h000FFFFFF.
- Zeros: a=32'h00000000, b=32'h80000000 -> zero_a=zero_b=1, sign_b=1, man=0, exp=0. Subnormal a=32'h00000001 -> sub_a=1, man_a=33'h000000001.
- With FPM_FE_VALID_EN: in_valid pulse with a=32'h40000000, then in_valid=0 with a changed -> out_valid high exactly 1 cycle, 2 edges later, and outputs hold 2.0 fields afterwards.
